// File: rtl/sprite_bank_ram.sv
// -----------------------------------------------------------------------------
// sprite_bank_ram
//
// Multi-slot sprite bitmap store. NUM_SPR sprites of SPR_W x SPR_H palette
// indices live in one block RAM; slot s starts at address s*SPR_W*SPR_H and is
// stored in raster order (row 0 col 0 first).
//
// Two independent users share the array:
//   * a pipelined pixel-read port for the draw path, addressed as
//     (sprite, x, y), fixed latency 2, one request per cycle;
//   * a streaming loader FSM (IDLE -> LOAD -> DONE -> IDLE) that rewrites one
//     whole slot from a valid/ready pixel stream.
//
// Handshake: a loader pixel transfers on every rising Clk edge where
// ld_valid && ld_ready are both high. ld_ready is high only while the FSM is
// in LOAD, and does not depend combinationally on ld_valid.
//
// Optional feature macro: SPRITE_FLIP_EN
//   defined   : rd_flip_h mirrors the column (x_eff = SPR_W-1-rd_x); the range
//               check still uses the unmirrored rd_x.
//   undefined : x_eff = rd_x; rd_flip_h is accepted but ignored.
//
// Ports
//   Clk, Reset      clock; synchronous active-high reset
//   rd_en           pixel read request
//   rd_sprite       slot to read
//   rd_x, rd_y      pixel column / row
//   rd_flip_h       horizontal mirror request
//   rd_valid        rd_data / rd_transparent valid this cycle
//   rd_data         palette index (TRANSP_IDX when out of range)
//   rd_transparent  rd_data == TRANSP_IDX, or request out of range
//   ld_start        begin loading slot ld_sprite (ignored unless IDLE)
//   ld_sprite       slot to load
//   ld_valid        ld_data holds a pixel
//   ld_data         pixel, raster order
//   ld_ready        loader accepts ld_data
//   ld_busy         loader not IDLE
//   ld_done         one-cycle pulse after the last pixel of a slot is written
//   ld_state        loader FSM state (0=IDLE, 1=LOAD, 2=DONE), for debug
// -----------------------------------------------------------------------------
module sprite_bank_ram #(
    parameter int    DATA_W     = 5,
    parameter int    SPR_W      = 20,
    parameter int    SPR_H      = 20,
    parameter int    NUM_SPR    = 4,
    parameter int    TRANSP_IDX = 0,
    parameter string INIT_FILE  = "",
    localparam int   SW         = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1,
    localparam int   XW         = (SPR_W > 1) ? $clog2(SPR_W) : 1,
    localparam int   YW         = (SPR_H > 1) ? $clog2(SPR_H) : 1
) (
    input  logic              Clk,
    input  logic              Reset,
    // pixel read port
    input  logic              rd_en,
    input  logic [SW-1:0]     rd_sprite,
    input  logic [XW-1:0]     rd_x,
    input  logic [YW-1:0]     rd_y,
    input  logic              rd_flip_h,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_transparent,
    // streaming loader
    input  logic              ld_start,
    input  logic [SW-1:0]     ld_sprite,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              ld_done,
    output logic [1:0]        ld_state
);

    localparam int SPR_PIX = SPR_W * SPR_H;
    localparam int DEPTH   = NUM_SPR * SPR_PIX;
    localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW      = (SPR_PIX > 1) ? $clog2(SPR_PIX) : 1;

    localparam logic [DATA_W-1:0] TRANSP_D = DATA_W'(TRANSP_IDX);
    localparam logic [PW-1:0]     LAST_PIX = PW'(SPR_PIX - 1);

    // -------------------------------------------------------------------------
    // Storage. Contents are never cleared by Reset.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // -------------------------------------------------------------------------
    // Loader FSM
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ld_state_t;

    ld_state_t     state;
    logic [PW-1:0] cnt;
    logic [AW-1:0] base;
    logic          ld_slot_ok;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    assign ld_slot_ok = (32'(ld_sprite) < NUM_SPR);
    assign ld_state   = state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            base     <= '0;
            ld_ready <= 1'b0;
            ld_busy  <= 1'b0;
            ld_done  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ld_done <= 1'b0;
                    if (ld_start && ld_slot_ok) begin
                        base     <= AW'(32'(ld_sprite) * SPR_PIX);
                        cnt      <= '0;
                        state    <= ST_LOAD;
                        ld_ready <= 1'b1;
                        ld_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // ld_ready is high throughout LOAD, so ld_valid alone
                    // marks an accepted pixel here.
                    if (ld_valid) begin
                        if (cnt == LAST_PIX) begin
                            state    <= ST_DONE;
                            ld_ready <= 1'b0;
                            ld_done  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    ld_done <= 1'b0;
                    ld_busy <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    ld_ready <= 1'b0;
                    ld_busy  <= 1'b0;
                    ld_done  <= 1'b0;
                end
            endcase
        end
    end

    // A Reset cycle must not write: an aborted load keeps exactly the pixels
    // accepted before the reset.
    assign wr_en   = (state == ST_LOAD) && ld_valid && !Reset;
    assign wr_addr = base + AW'(cnt);

    // Write-only port; the read in stage 2 sees the pre-write value when both
    // touch the same address on the same edge.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem[wr_addr] <= ld_data;
        end
    end

    // -------------------------------------------------------------------------
    // Read pipeline, stage 1: address and range check
    // -------------------------------------------------------------------------
    logic [XW-1:0] x_eff;
    logic          rd_oor;
    logic [AW-1:0] rd_addr;

`ifndef SPRITE_FLIP_EN
    logic unused_flip;
    assign unused_flip = rd_flip_h;
`endif

    always_comb begin
        x_eff = rd_x;
`ifdef SPRITE_FLIP_EN
        if (rd_flip_h) begin
            x_eff = XW'(SPR_W - 1) - rd_x;
        end
`endif
        // Range check deliberately uses the unmirrored column.
        rd_oor  = (32'(rd_sprite) >= NUM_SPR) ||
                  (32'(rd_x)      >= SPR_W)   ||
                  (32'(rd_y)      >= SPR_H);
        rd_addr = AW'(32'(rd_sprite) * SPR_PIX + 32'(rd_y) * SPR_W + 32'(x_eff));
    end

    logic          s1_valid;
    logic          s1_oor;
    logic [AW-1:0] s1_addr;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid <= 1'b0;
            s1_oor   <= 1'b0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                s1_oor  <= rd_oor;
                s1_addr <= rd_addr;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read pipeline, stage 2: memory access. Outputs hold while idle.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rd_valid       <= 1'b0;
            rd_data        <= '0;
            rd_transparent <= 1'b0;
        end else begin
            rd_valid <= s1_valid;
            if (s1_valid) begin
                if (s1_oor) begin
                    rd_data        <= TRANSP_D;
                    rd_transparent <= 1'b1;
                end else begin
                    rd_data        <= mem[s1_addr];
                    rd_transparent <= (mem[s1_addr] == TRANSP_D);
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_bank_ram.sv
module tb_sprite_bank_ram;

  localparam int DATA_W  = 5;
  localparam int SPR_W   = 20;
  localparam int SPR_H   = 20;
  localparam int SPR_PIX = SPR_W * SPR_H;

  // ---------------- clock / reset ----------------
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        rd_en = 1'b0;
  logic [1:0]  rd_sprite = '0;
  logic [4:0]  rd_x = '0;
  logic [4:0]  rd_y = '0;
  logic        rd_flip_h = 1'b0;
  logic        rd_valid;
  logic [4:0]  rd_data;
  logic        rd_transparent;
  logic        ld_start = 1'b0;
  logic [1:0]  ld_sprite = '0;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_data = '0;
  logic        ld_ready;
  logic        ld_busy;
  logic        ld_done;
  logic [1:0]  ld_state;

  always #5 Clk = ~Clk;

  sprite_bank_ram dut (
    .Clk(Clk), .Reset(Reset),
    .rd_en(rd_en), .rd_sprite(rd_sprite), .rd_x(rd_x), .rd_y(rd_y),
    .rd_flip_h(rd_flip_h), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_transparent(rd_transparent),
    .ld_start(ld_start), .ld_sprite(ld_sprite), .ld_valid(ld_valid),
    .ld_data(ld_data), .ld_ready(ld_ready), .ld_busy(ld_busy),
    .ld_done(ld_done), .ld_state(ld_state)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // pixel patterns written by the loader
  function automatic logic [4:0] pix(input int pat, input int i);
    case (pat)
      0:       return 5'(i % 32);
      1:       return 5'((i * 3 + 7) % 32);
      default: return 5'(31 - (i % 32));
    endcase
  endfunction

  task automatic tick();
    @(negedge Clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic read_px(input int spr, input int x, input int y, input logic flip,
                         output logic [4:0] d, output logic t);
    rd_en = 1'b1; rd_sprite = 2'(spr); rd_x = 5'(x); rd_y = 5'(y); rd_flip_h = flip;
    tick();
    rd_en = 1'b0;
    check("rd_valid_not_early", 32'(rd_valid), 32'd0);
    tick();
    check("rd_valid_latency2", 32'(rd_valid), 32'd1);
    d = rd_data;
    t = rd_transparent;
  endtask

  // mode 0: ld_valid held high; mode 1: 50% throttle plus a stray ld_start
  task automatic load(input int slot, input int pat, input int mode, input int stop_at,
                      output int ready_cycles);
    int cnt;
    int cyc;
    bit stray_done;
    cnt = 0; cyc = 0; stray_done = 0; ready_cycles = 0;
    ld_start = 1'b1; ld_sprite = 2'(slot);
    tick();
    ld_start = 1'b0;
    while (cnt < stop_at && cyc < 5000) begin
      ld_valid = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      ld_data  = pix(pat, cnt);
      if (mode == 1 && cnt == 50 && !stray_done) begin
        ld_start = 1'b1; ld_sprite = 2'd3; stray_done = 1;
      end else begin
        ld_start = 1'b0;
      end
      if (ld_ready) ready_cycles++;
      if (ld_valid && ld_ready) cnt++;
      cyc++;
      tick();
    end
    ld_valid = 1'b0; ld_start = 1'b0;
    if (cyc >= 5000) check("load_timeout", 32'(cnt), 32'(stop_at));
  endtask

  task automatic load_full(input int slot, input int pat);
    int rc;
    load(slot, pat, 0, SPR_PIX, rc);
    check("ld_ready_cycles", 32'(rc), 32'(SPR_PIX));
    check("ld_done_pulse", 32'(ld_done), 32'd1);
    check("ld_ready_low_in_done", 32'(ld_ready), 32'd0);
    check("ld_busy_in_done", 32'(ld_busy), 32'd1);
    tick();
    check("ld_done_cleared", 32'(ld_done), 32'd0);
    check("ld_busy_dropped", 32'(ld_busy), 32'd0);
    check("ld_state_idle", 32'(ld_state), 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int spr; int x; int y; logic flip; logic [4:0] d; logic t;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] d, d2, d3;
    logic       t;
    int         rc;
    int         idx [5];
    int         newp [5];

    // slot 1 holds i%32, slot 0 holds (3i+7)%32, slot 2 holds i%32
    vecs[0]  = '{1, 3, 2, 1'b0, 5'd11, 1'b0};
    vecs[1]  = '{1, 0, 0, 1'b0, 5'd0, 1'b1};
    vecs[2]  = '{1, 19, 19, 1'b0, 5'd15, 1'b0};
    vecs[3]  = '{1, 5, 10, 1'b0, 5'd13, 1'b0};
    vecs[4]  = '{1, 0, 1, 1'b0, 5'd20, 1'b0};
    vecs[5]  = '{1, 20, 0, 1'b0, 5'd0, 1'b1};
    vecs[6]  = '{1, 0, 20, 1'b0, 5'd0, 1'b1};
    vecs[7]  = '{1, 31, 31, 1'b0, 5'd0, 1'b1};
`ifdef SPRITE_FLIP_EN
    vecs[8]  = '{1, 0, 0, 1'b1, 5'd19, 1'b0};
    vecs[9]  = '{1, 19, 1, 1'b1, 5'd20, 1'b0};
`else
    vecs[8]  = '{1, 0, 0, 1'b1, 5'd0, 1'b1};
    vecs[9]  = '{1, 19, 1, 1'b1, 5'd7, 1'b0};
`endif
    vecs[10] = '{1, 20, 0, 1'b1, 5'd0, 1'b1};
    vecs[11] = '{0, 10, 15, 1'b0, 5'd9, 1'b0};
    vecs[12] = '{2, 7, 3, 1'b0, 5'd3, 1'b0};

    // reset state
    tick(); tick(); tick();
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_rd_transparent", 32'(rd_transparent), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_ld_busy", 32'(ld_busy), 32'd0);
    check("rst_ld_done", 32'(ld_done), 32'd0);
    check("rst_ld_state", 32'(ld_state), 32'd0);
    Reset = 1'b0;
    tick();

    // full-slot loads
    load_full(1, 0);
    load_full(0, 1);
    load_full(2, 0);

    // table-driven reads
    for (int i = 0; i < NV; i++) begin
      read_px(vecs[i].spr, vecs[i].x, vecs[i].y, vecs[i].flip, d, t);
      check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].d));
      check($sformatf("vec%0d_transp", i), 32'(t), 32'(vecs[i].t));
    end

    // outputs hold while rd_valid is low
    tick(); tick();
    check("hold_rd_valid", 32'(rd_valid), 32'd0);
    check("hold_rd_data", 32'(rd_data), 32'(vecs[NV-1].d));

    // back-to-back reads on consecutive cycles
    rd_en = 1'b1; rd_sprite = 2'd1; rd_flip_h = 1'b0;
    rd_x = 5'd3; rd_y = 5'd2;
    tick();
    rd_x = 5'd5; rd_y = 5'd10;
    tick();
    check("b2b0_valid", 32'(rd_valid), 32'd1);
    check("b2b0_data", 32'(rd_data), 32'd11);
    rd_x = 5'd0; rd_y = 5'd1;
    tick();
    rd_en = 1'b0;
    check("b2b1_valid", 32'(rd_valid), 32'd1);
    check("b2b1_data", 32'(rd_data), 32'd13);
    tick();
    check("b2b2_valid", 32'(rd_valid), 32'd1);
    check("b2b2_data", 32'(rd_data), 32'd20);
    tick();

    // throttled partial reload of slot 2, stray ld_start, then reset abort
    load(2, 2, 1, 100, rc);
    check("partial_busy", 32'(ld_busy), 32'd1);
    check("partial_state_load", 32'(ld_state), 32'd1);
    Reset = 1'b1; ld_valid = 1'b1; ld_data = pix(2, 100);
    tick();
    Reset = 1'b0; ld_valid = 1'b0;
    check("abort_busy", 32'(ld_busy), 32'd0);
    check("abort_ready", 32'(ld_ready), 32'd0);
    check("abort_state", 32'(ld_state), 32'd0);
    idx[0] = 0; idx[1] = 50; idx[2] = 99; idx[3] = 100; idx[4] = 200;
    newp[0] = 1; newp[1] = 1; newp[2] = 1; newp[3] = 0; newp[4] = 0;
    for (int k = 0; k < 5; k++) begin
      read_px(2, idx[k] % SPR_W, idx[k] / SPR_W, 1'b0, d, t);
      check($sformatf("abort_pix%0d", idx[k]), 32'(d),
            32'(newp[k] != 0 ? pix(2, idx[k]) : pix(0, idx[k])));
    end

    // same-cycle write and read of one address
    ld_start = 1'b1; ld_sprite = 2'd0;
    tick();
    ld_start = 1'b0;
    check("wr_rd_ready", 32'(ld_ready), 32'd1);
    rd_en = 1'b1; rd_sprite = 2'd0; rd_x = 5'd0; rd_y = 5'd0; rd_flip_h = 1'b0;
    tick();
    ld_valid = 1'b1; ld_data = pix(2, 0);
    tick();
    ld_valid = 1'b0; rd_en = 1'b0;
    d2 = rd_data;
    check("same_cycle_valid", 32'(rd_valid), 32'd1);
    check("same_cycle_old", 32'(d2), 32'(pix(1, 0)));
    tick();
    d3 = rd_data;
    check("reread_valid", 32'(rd_valid), 32'd1);
    check("reread_new", 32'(d3), 32'(pix(2, 0)));
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
